// File: rtl/scroll_latch.sv
// scroll_latch: two-layer X/Y scroll and priority latch on the CPU bus strobe.
// Define SCROLL_LATCH_DOUBLE_BUFFER_EN to hold writes in a shadow set until the nVBLANK falling edge.
module scroll_latch (
  input  logic       CLK_6M,
  input  logic       nRESET,
  input  logic       nLATCH,
  input  logic       nWE,
  input  logic [2:0] A,
  input  logic [7:0] D,
  input  logic       nVBLANK,
  output logic [8:0] SCROLLX_A,
  output logic [7:0] SCROLLY_A,
  output logic [2:0] PRI_A,
  output logic [8:0] SCROLLX_B,
  output logic [7:0] SCROLLY_B,
  output logic [2:0] PRI_B,
  output logic       PENDING
);
  typedef enum logic {IDLE, ARMED} state_t;
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] pri;
  } layer_t;
  state_t       state_q;
  logic [2:0]   hold_a_q;
  logic [7:0]   hold_d_q;
  layer_t [1:0] shd_q, shd_d, act_q, act_d;
  logic         pend_q, pend_d;
  logic         strobe, wr_en, wr_valid;
  assign strobe   = !nLATCH && !nWE;
  assign wr_en    = (state_q == ARMED) && nLATCH;
  assign wr_valid = wr_en && (hold_a_q[1:0] != 2'd3);
  // Every non-strobe cycle leaves ARMED: either completion (nLATCH high) or abort (nWE high).
  always_ff @(posedge CLK_6M or negedge nRESET)
    if (!nRESET) begin
      state_q  <= IDLE;
      hold_a_q <= '0;
      hold_d_q <= '0;
    end else begin
      state_q <= strobe ? ARMED : IDLE;
      if (strobe) begin
        hold_a_q <= A;
        hold_d_q <= D;
      end
    end
  always_comb begin
    shd_d = shd_q;
    if (wr_valid) begin
      if (hold_a_q[1:0] == 2'd0) begin
        shd_d[hold_a_q[2]].x[8] = hold_d_q[0];
        shd_d[hold_a_q[2]].pri  = hold_d_q[3:1];
      end else if (hold_a_q[1:0] == 2'd1) begin
        shd_d[hold_a_q[2]].x[7:0] = hold_d_q;
      end else begin
        shd_d[hold_a_q[2]].y = hold_d_q;
      end
    end
  end
`ifdef SCROLL_LATCH_DOUBLE_BUFFER_EN
  logic vb_q, commit;
  assign commit = vb_q && !nVBLANK;
  // Committing shd_d rather than shd_q lets a coincident write bypass straight to the outputs.
  assign act_d  = commit ? shd_d : act_q;
  assign pend_d = !commit && (wr_valid || pend_q);
  always_ff @(posedge CLK_6M or negedge nRESET)
    if (!nRESET) vb_q <= 1'b1;
    else vb_q <= nVBLANK;
`else
  logic unused_vblank;
  assign unused_vblank = nVBLANK;
  assign act_d  = shd_q;
  assign pend_d = wr_valid;
`endif
  always_ff @(posedge CLK_6M or negedge nRESET)
    if (!nRESET) begin
      shd_q  <= '0;
      act_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      act_q  <= act_d;
      pend_q <= pend_d;
    end
  assign SCROLLX_A = act_q[0].x;
  assign SCROLLY_A = act_q[0].y;
  assign PRI_A     = act_q[0].pri;
  assign SCROLLX_B = act_q[1].x;
  assign SCROLLY_B = act_q[1].y;
  assign PRI_B     = act_q[1].pri;
  assign PENDING   = pend_q;
endmodule

// File: tb/tb_scroll_latch.sv
// tb_scroll_latch: directed checks of the scroll latch in whichever buffering mode is built.
module tb_scroll_latch;
  logic       CLK_6M = 1'b0, nRESET = 1'b0, nLATCH = 1'b1, nWE = 1'b1, nVBLANK = 1'b0;
  logic [2:0] A = '0;
  logic [7:0] D = '0;
  logic [8:0] SCROLLX_A, SCROLLX_B;
  logic [7:0] SCROLLY_A, SCROLLY_B;
  logic [2:0] PRI_A, PRI_B;
  logic       PENDING;
  int checks = 0, errors = 0;

  scroll_latch dut (
    .CLK_6M(CLK_6M), .nRESET(nRESET), .nLATCH(nLATCH), .nWE(nWE), .A(A), .D(D),
    .nVBLANK(nVBLANK), .SCROLLX_A(SCROLLX_A), .SCROLLY_A(SCROLLY_A), .PRI_A(PRI_A),
    .SCROLLX_B(SCROLLX_B), .SCROLLY_B(SCROLLY_B), .PRI_B(PRI_B), .PENDING(PENDING)
  );

  always #5 CLK_6M = ~CLK_6M;

  task automatic tick();
    @(posedge CLK_6M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    A = a;
    D = d;
    nLATCH = 1'b0;
    nWE = 1'b0;
    tick();
    nLATCH = 1'b1;
    nWE = 1'b1;
    tick();
  endtask

  initial begin
    #2;
    chk("rst_async_xa", SCROLLX_A, 9'h0);
    chk("rst_async_pend", {8'h0, PENDING}, 9'h0);
    #20 nRESET = 1'b1;
    tick();
    chk("rel_xa", SCROLLX_A, 9'h0);
    chk("rel_ya", {1'b0, SCROLLY_A}, 9'h0);
    chk("rel_pa", {6'h0, PRI_A}, 9'h0);
    chk("rel_xb", SCROLLX_B, 9'h0);
    chk("rel_yb", {1'b0, SCROLLY_B}, 9'h0);
    chk("rel_pb", {6'h0, PRI_B}, 9'h0);
    chk("rel_pend", {8'h0, PENDING}, 9'h0);
    nVBLANK = 1'b1;
    tick();
`ifdef SCROLL_LATCH_DOUBLE_BUFFER_EN
    wr(3'd1, 8'h34);
    chk("db_pend_w1", {8'h0, PENDING}, 9'h1);
    chk("db_xa_hold1", SCROLLX_A, 9'h0);
    wr(3'd0, 8'h0B);
    tick();
    chk("db_xa_hold2", SCROLLX_A, 9'h0);
    chk("db_pend_w2", {8'h0, PENDING}, 9'h1);
    nVBLANK = 1'b0;
    tick();
    chk("db_commit_xa", SCROLLX_A, 9'h134);
    chk("db_commit_pa", {6'h0, PRI_A}, 9'h5);
    chk("db_commit_pend", {8'h0, PENDING}, 9'h0);
    nVBLANK = 1'b1;
    tick();
    A = 3'd6; D = 8'h80; nLATCH = 1'b0; nWE = 1'b0;
    tick();
    nLATCH = 1'b1; nWE = 1'b1; nVBLANK = 1'b0;
    tick();
    chk("db_bypass_yb", {1'b0, SCROLLY_B}, 9'h080);
    chk("db_bypass_pend", {8'h0, PENDING}, 9'h0);
    nVBLANK = 1'b1;
    tick();
    chk("db_bypass_pend2", {8'h0, PENDING}, 9'h0);
`else
    wr(3'd2, 8'h5A);
    chk("nb_ya_before", {1'b0, SCROLLY_A}, 9'h0);
    chk("nb_pend_on", {8'h0, PENDING}, 9'h1);
    tick();
    chk("nb_ya_after", {1'b0, SCROLLY_A}, 9'h05A);
    chk("nb_pend_off", {8'h0, PENDING}, 9'h0);
    wr(3'd1, 8'h34);
    chk("nb_pend_w1", {8'h0, PENDING}, 9'h1);
    wr(3'd0, 8'h0B);
    chk("nb_xa_low", SCROLLX_A, 9'h034);
    chk("nb_pend_w2", {8'h0, PENDING}, 9'h1);
    tick();
    chk("nb_xa_full", SCROLLX_A, 9'h134);
    chk("nb_pa", {6'h0, PRI_A}, 9'h5);
    chk("nb_ya_kept", {1'b0, SCROLLY_A}, 9'h05A);
    wr(3'd6, 8'h80);
    tick();
    chk("nb_yb", {1'b0, SCROLLY_B}, 9'h080);
    A = 3'd4; D = 8'h0F; nLATCH = 1'b0; nWE = 1'b0;
    tick();
    A = 3'd5; D = 8'h22;
    tick();
    nLATCH = 1'b1; nWE = 1'b1;
    tick();
    chk("nb_merge_pend", {8'h0, PENDING}, 9'h1);
    tick();
    chk("nb_merge_xb", SCROLLX_B, 9'h022);
    chk("nb_merge_pb", {6'h0, PRI_B}, 9'h0);
`endif
    A = 3'd5; D = 8'hFF; nLATCH = 1'b0; nWE = 1'b0;
    tick();
    nWE = 1'b1;
    tick();
    nLATCH = 1'b1;
    tick();
    chk("abort_pend", {8'h0, PENDING}, 9'h0);
    tick();
    chk("abort_pend2", {8'h0, PENDING}, 9'h0);
    wr(3'd3, 8'hFF);
    chk("resv_pend", {8'h0, PENDING}, 9'h0);
    tick();
    chk("resv_pend2", {8'h0, PENDING}, 9'h0);
    A = 3'd6; D = 8'h77; nLATCH = 1'b0; nWE = 1'b1;
    tick();
    nLATCH = 1'b1;
    tick();
    chk("read_pend", {8'h0, PENDING}, 9'h0);
    tick();
    chk("read_yb", {1'b0, SCROLLY_B}, 9'h080);
    chk("keep_xa", SCROLLX_A, 9'h134);
    A = 3'd2; D = 8'h99; nLATCH = 1'b0; nWE = 1'b0;
    tick();
    #2 nRESET = 1'b0;
    #1;
    chk("armrst_xa", SCROLLX_A, 9'h0);
    chk("armrst_yb", {1'b0, SCROLLY_B}, 9'h0);
    nWE = 1'b1;
    #3 nRESET = 1'b1;
    tick();
    nLATCH = 1'b1;
    tick();
    chk("armrst_pend", {8'h0, PENDING}, 9'h0);
    nVBLANK = 1'b1;
    tick();
    nVBLANK = 1'b0;
    tick();
    tick();
    chk("armrst_ya", {1'b0, SCROLLY_A}, 9'h0);
    chk("armrst_pend2", {8'h0, PENDING}, 9'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
